shader_run_controller: RTL and testbench
========================================

SHADER_RUN_CONTROLLER -- requirements
Module: shader_run_controller

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, byte address width of the external write port.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, load data width.
REQ-003 SHALL have parameter WATCHDOG_CYCLES, default 1000000, run-cycle limit used only when SHADER_RUN_WATCHDOG_EN is defined.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 start  input  1  single-cycle request to begin a load-and-run sequence.
REQ-008 load_valid  input  1  host beat valid.
REQ-009 load_ready  output  1  controller accepts a beat this cycle.
REQ-010 load_data  input  WORD_WIDTH  beat payload.
REQ-011 load_is_data  input  1  0 = instruction RAM word, 1 = data RAM word.
REQ-012 load_last  input  1  final beat of the image.
REQ-013 ext_write_address  output  ADDRESS_WIDTH  byte address to the shader system.
REQ-014 ext_write_data  output  WORD_WIDTH  write word.
REQ-015 ext_enable_write_inst, ext_enable_write_data  output  1 each  one-cycle write strobes.
REQ-016 core_reset_n  output  1  shader core reset, active-low.
REQ-017 run  output  1  shader core run enable.
REQ-018 halted, exception  input  1 each  shader core status.
REQ-019 done  output  1  sequence finished; status outputs valid.
REQ-020 fault, timeout, overflow  output  1 each  sticky status flags.
REQ-021 run_cycles  output  32  cycles spent in RUN, saturating at 0xFFFFFFFF.

Function
REQ-022 SHALL implement states IDLE, LOAD, DRAIN, RUN, DONE.
REQ-023 IDLE: start -> LOAD; clear inst/data address counters, run_cycles, fault, timeout, overflow.
REQ-024 load_ready SHALL be 1 only in LOAD; a beat is accepted when load_valid and load_ready are both 1.
REQ-025 Beat accepted at cycle N SHALL drive address, data, and exactly one strobe (per load_is_data) during cycle N+1 only.
REQ-026 The inst and data counters SHALL start at 0 and advance by 4 per accepted beat of their type, independently.
REQ-027 Counter wrap from 2^ADDRESS_WIDTH-4 to 0 SHALL set overflow; the write still occurs at the wrapped address.
REQ-028 Accepted beat with load_last -> DRAIN at N+1 (write issued), RUN at N+2.
REQ-029 core_reset_n SHALL be 0 in IDLE, LOAD, DRAIN; 1 in RUN and DONE.
REQ-030 run SHALL be 1 only in RUN; strobes SHALL never be 1 while run is 1.
REQ-031 RUN: run_cycles increments each cycle; halted or exception sampled 1 -> DONE next cycle.
REQ-032 halted and exception both 1 in the same cycle -> DONE with fault=1.
REQ-033 exception -> fault=1; halted alone -> fault=0.
REQ-034 DONE: done=1, flags hold; start -> LOAD with the clears of REQ-023.
REQ-035 start SHALL be ignored in LOAD, DRAIN, RUN.
REQ-036 Strobes, ext_write_address and ext_write_data SHALL be 0 in every cycle without a pending write.

Reset
REQ-037 reset SHALL force IDLE, all counters/flags 0, run=0, core_reset_n=0, load_ready=0, done=0, strobes=0 immediately, including mid-LOAD and mid-RUN.
REQ-038 A write pending from cycle N SHALL be dropped if reset asserts before cycle N+1.

Configuration
REQ-039 With SHADER_RUN_WATCHDOG_EN defined, run_cycles reaching WATCHDOG_CYCLES in RUN SHALL move to DONE next cycle with timeout=1, fault=0, unless halted/exception is sampled in the same cycle, which takes priority.
REQ-040 Without SHADER_RUN_WATCHDOG_EN, timeout SHALL be constant 0 and RUN SHALL exit only on halted or exception.

Verification
REQ-041 start, 3 inst beats 0x11/0x22/0x33 then 1 data beat 0xAA with last -> inst strobes at addresses 0,4,8, data strobe at 0, run=1 two cycles after the last accept.
REQ-042 RUN, halted=1 after 10 cycles -> done=1, fault=0, run_cycles=10, run=0.
REQ-043 halted=1 and exception=1 in the same cycle -> done=1, fault=1.
REQ-044 16385 inst beats at ADDRESS_WIDTH=16 -> 16385th write at address 0, overflow=1.
REQ-045 reset asserted mid-LOAD with load_valid held -> load_ready=0, no strobe, state IDLE; a new start reloads from address 0.
REQ-046 SHADER_RUN_WATCHDOG_EN, WATCHDOG_CYCLES=50, core never halts -> done=1, timeout=1, run_cycles=50.

Source files
------------

// File: rtl/shader_run_controller.sv
// shader_run_controller
// ---------------------------------------------------------------------------
// Sequences a shader core through image load and execution:
//   IDLE -> (start) -> LOAD -> (last beat) -> DRAIN -> RUN -> (halt/exc) -> DONE
// During LOAD, host beats are turned into one-cycle writes into the shader's
// instruction or data RAM. Each RAM has its own byte-address counter that
// advances by 4 per beat. The core is held in reset until RUN. Its cycles are
// counted while it runs, and the outcome is reported through sticky flags.
//
// Optional feature: define SHADER_RUN_WATCHDOG_EN to bound RUN to
// WATCHDOG_CYCLES cycles. On expiry the block moves to DONE with timeout=1.
// Without that macro, timeout is always 0 and RUN ends only on halted/exception.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   start                  begin a load-and-run sequence (honoured in IDLE/DONE)
//   load_valid/load_ready  host beat handshake (ready only in LOAD)
//   load_data              beat payload
//   load_is_data           0 = instruction word, 1 = data word
//   load_last              final beat of the image
//   ext_write_address      byte address of the current write (0 when idle)
//   ext_write_data         write word (0 when idle)
//   ext_enable_write_inst  instruction RAM write strobe
//   ext_enable_write_data  data RAM write strobe
//   core_reset_n           shader core reset, active-low
//   run                    shader core run enable
//   halted, exception      shader core status
//   done                   sequence finished, status valid
//   fault/timeout/overflow sticky status flags
//   run_cycles             cycles spent in RUN, saturating
// ---------------------------------------------------------------------------
module shader_run_controller #(
    parameter int ADDRESS_WIDTH   = 16,
    parameter int WORD_WIDTH      = 32,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [WORD_WIDTH-1:0]    load_data,
    input  logic                     load_is_data,
    input  logic                     load_last,
    output logic [ADDRESS_WIDTH-1:0] ext_write_address,
    output logic [WORD_WIDTH-1:0]    ext_write_data,
    output logic                     ext_enable_write_inst,
    output logic                     ext_enable_write_data,
    output logic                     core_reset_n,
    output logic                     run,
    input  logic                     halted,
    input  logic                     exception,
    output logic                     done,
    output logic                     fault,
    output logic                     timeout,
    output logic                     overflow,
    output logic [31:0]              run_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = {ADDRESS_WIDTH{1'b0}};
    localparam logic [WORD_WIDTH-1:0]    WORD_ZERO = {WORD_WIDTH{1'b0}};

    state_t                   state_r;
    state_t                   state_next_s;

    logic [ADDRESS_WIDTH-1:0] inst_addr_r;
    logic [ADDRESS_WIDTH-1:0] data_addr_r;
    logic [ADDRESS_WIDTH-1:0] addr_sel_s;
    logic [ADDRESS_WIDTH-1:0] addr_inc_s;
    logic                     addr_wrap_s;

    logic                     accept_s;
    logic                     clear_s;
    logic                     core_stop_s;
    logic                     wd_expire_s;
    logic [31:0]              run_cycles_r;
    logic [31:0]              run_cycles_inc_s;

    logic                     fault_r;
    logic                     timeout_r;
    logic                     overflow_r;

    logic                     load_ready_r;
    logic                     run_r;
    logic                     core_reset_n_r;
    logic                     done_r;

    logic [ADDRESS_WIDTH-1:0] wr_addr_r;
    logic [WORD_WIDTH-1:0]    wr_data_r;
    logic                     wr_inst_r;
    logic                     wr_data_en_r;

    // A beat is taken only in LOAD. A start from IDLE/DONE clears the run status.
    assign accept_s    = (state_r == ST_LOAD) && load_valid;
    assign clear_s     = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign core_stop_s = halted || exception;

    // The beat goes to the counter of its RAM type. The counter wraps to 0
    // after the last word-aligned address.
    assign addr_sel_s  = load_is_data ? data_addr_r : inst_addr_r;
    assign addr_inc_s  = addr_sel_s + ADDR_STEP;
    assign addr_wrap_s = (addr_inc_s == ADDR_ZERO);

    assign run_cycles_inc_s = (run_cycles_r == 32'hFFFF_FFFF) ? run_cycles_r
                                                               : run_cycles_r + 32'd1;

`ifdef SHADER_RUN_WATCHDOG_EN
    localparam logic [31:0] WD_LIMIT = 32'(WATCHDOG_CYCLES);
    // Expiry is judged on the count this RUN cycle will reach.
    assign wd_expire_s = (state_r == ST_RUN) && (run_cycles_inc_s >= WD_LIMIT);
`else
    logic [31:0] unused_wd_limit_s;
    assign unused_wd_limit_s = 32'(WATCHDOG_CYCLES);
    assign wd_expire_s       = 1'b0;
`endif

    // Next-state logic. A core stop has priority over watchdog expiry.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_LOAD;
                else       state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (accept_s && load_last) state_next_s = ST_DRAIN;
                else                       state_next_s = ST_LOAD;
            end
            ST_DRAIN: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                if (core_stop_s)      state_next_s = ST_DONE;
                else if (wd_expire_s) state_next_s = ST_DONE;
                else                  state_next_s = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_next_s = ST_LOAD;
                else       state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Control outputs are registered from the next state, so each one is a
    // clean flop that lines up with the state it describes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_ready_r   <= 1'b0;
            run_r          <= 1'b0;
            core_reset_n_r <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            load_ready_r   <= (state_next_s == ST_LOAD);
            run_r          <= (state_next_s == ST_RUN);
            core_reset_n_r <= (state_next_s == ST_RUN) || (state_next_s == ST_DONE);
            done_r         <= (state_next_s == ST_DONE);
        end
    end

    // The write port shows an accepted beat for exactly the following cycle.
    // It returns to all-zero whenever no write is pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_addr_r    <= ADDR_ZERO;
            wr_data_r    <= WORD_ZERO;
            wr_inst_r    <= 1'b0;
            wr_data_en_r <= 1'b0;
        end else if (accept_s) begin
            wr_addr_r    <= addr_sel_s;
            wr_data_r    <= load_data;
            wr_inst_r    <= ~load_is_data;
            wr_data_en_r <= load_is_data;
        end else begin
            wr_addr_r    <= ADDR_ZERO;
            wr_data_r    <= WORD_ZERO;
            wr_inst_r    <= 1'b0;
            wr_data_en_r <= 1'b0;
        end
    end

    // Address counters and the sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_addr_r <= ADDR_ZERO;
            data_addr_r <= ADDR_ZERO;
            overflow_r  <= 1'b0;
        end else if (clear_s) begin
            inst_addr_r <= ADDR_ZERO;
            data_addr_r <= ADDR_ZERO;
            overflow_r  <= 1'b0;
        end else if (accept_s) begin
            if (load_is_data) data_addr_r <= addr_inc_s;
            else              inst_addr_r <= addr_inc_s;
            if (addr_wrap_s)  overflow_r  <= 1'b1;
        end
    end

    // Run-cycle counter and the outcome flags, which are captured on RUN exit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cycles_r <= 32'd0;
            fault_r      <= 1'b0;
            timeout_r    <= 1'b0;
        end else if (clear_s) begin
            run_cycles_r <= 32'd0;
            fault_r      <= 1'b0;
            timeout_r    <= 1'b0;
        end else if (state_r == ST_RUN) begin
            run_cycles_r <= run_cycles_inc_s;
            if (core_stop_s)      fault_r   <= exception;
            else if (wd_expire_s) timeout_r <= 1'b1;
        end
    end

    assign load_ready            = load_ready_r;
    assign run                   = run_r;
    assign core_reset_n          = core_reset_n_r;
    assign done                  = done_r;
    assign ext_write_address     = wr_addr_r;
    assign ext_write_data        = wr_data_r;
    assign ext_enable_write_inst = wr_inst_r;
    assign ext_enable_write_data = wr_data_en_r;
    assign fault                 = fault_r;
    assign timeout               = timeout_r;
    assign overflow              = overflow_r;
    assign run_cycles            = run_cycles_r;

endmodule

// File: tb/tb_shader_run_controller.sv
// Testbench for shader_run_controller.
// The reference model is kept at the level of the behaviour: it counts the
// beats of each type to predict write addresses and overflow, and it counts
// the cycles it leaves the core running to predict run_cycles and the flags.
module tb_shader_run_controller;

    localparam int AW   = 16;
    localparam int WW   = 32;
    localparam int WD   = 50;
    localparam int AMOD = 1 << AW;

    logic          clock;
    logic          reset;
    logic          start;
    logic          load_valid;
    logic          load_ready;
    logic [WW-1:0] load_data;
    logic          load_is_data;
    logic          load_last;
    logic [AW-1:0] ext_write_address;
    logic [WW-1:0] ext_write_data;
    logic          ext_enable_write_inst;
    logic          ext_enable_write_data;
    logic          core_reset_n;
    logic          run;
    logic          halted;
    logic          exception;
    logic          done;
    logic          fault;
    logic          timeout;
    logic          overflow;
    logic [31:0]   run_cycles;

    int n_total = 0;
    int n_pass  = 0;
    int inst_beats;
    int data_beats;

    shader_run_controller #(
        .ADDRESS_WIDTH  (AW),
        .WORD_WIDTH     (WW),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .start                (start),
        .load_valid           (load_valid),
        .load_ready           (load_ready),
        .load_data            (load_data),
        .load_is_data         (load_is_data),
        .load_last            (load_last),
        .ext_write_address    (ext_write_address),
        .ext_write_data       (ext_write_data),
        .ext_enable_write_inst(ext_enable_write_inst),
        .ext_enable_write_data(ext_enable_write_data),
        .core_reset_n         (core_reset_n),
        .run                  (run),
        .halted               (halted),
        .exception            (exception),
        .done                 (done),
        .fault                (fault),
        .timeout              (timeout),
        .overflow             (overflow),
        .run_cycles           (run_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_no_write(input string tag);
        chk_b({tag, "_inst_strobe"}, ext_enable_write_inst, 1'b0);
        chk_b({tag, "_data_strobe"}, ext_enable_write_data, 1'b0);
        chk_w({tag, "_addr"}, 32'(ext_write_address), 32'd0);
        chk_w({tag, "_data"}, ext_write_data, 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_b({tag, "_load_ready"}, load_ready, 1'b0);
        chk_b({tag, "_run"}, run, 1'b0);
        chk_b({tag, "_core_reset_n"}, core_reset_n, 1'b0);
        chk_b({tag, "_done"}, done, 1'b0);
        chk_b({tag, "_fault"}, fault, 1'b0);
        chk_b({tag, "_timeout"}, timeout, 1'b0);
        chk_b({tag, "_overflow"}, overflow, 1'b0);
        chk_w({tag, "_run_cycles"}, run_cycles, 32'd0);
        chk_no_write(tag);
    endtask

    // Pulse start from IDLE/DONE; the model restarts both counters at 0.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        inst_beats = 0;
        data_beats = 0;
        chk_b("start_load_ready", load_ready, 1'b1);
        chk_b("start_done_clear", done, 1'b0);
        chk_b("start_fault_clear", fault, 1'b0);
        chk_b("start_overflow_clear", overflow, 1'b0);
        chk_w("start_run_cycles_clear", run_cycles, 32'd0);
        chk_b("start_core_reset_n", core_reset_n, 1'b0);
    endtask

    // One accepted beat, followed by a check of the write it produces.
    task automatic send_beat(input bit is_d, input logic [31:0] d, input bit last);
        int n;
        int exp_a;
        load_valid   = 1'b1;
        load_is_data = is_d;
        load_data    = d;
        load_last    = last;
        chk_b("ready_before_beat", load_ready, 1'b1);
        n     = is_d ? data_beats : inst_beats;
        exp_a = (n * 4) % AMOD;
        if (is_d) data_beats++;
        else      inst_beats++;
        tick();
        load_valid   = 1'b0;
        load_is_data = 1'b0;
        load_data    = '0;
        load_last    = 1'b0;
        chk_b("wr_inst_strobe", ext_enable_write_inst, !is_d);
        chk_b("wr_data_strobe", ext_enable_write_data, is_d);
        chk_w("wr_addr", 32'(ext_write_address), 32'(exp_a));
        chk_w("wr_data", ext_write_data, d);
        chk_b("run_low_during_write", run, 1'b0);
        chk_b("overflow_model", overflow,
              (inst_beats * 4 >= AMOD) || (data_beats * 4 >= AMOD));
        chk_b("ready_after_beat", load_ready, !last);
    endtask

    // A LOAD cycle without a beat, carrying junk data and possibly a start
    // pulse that the controller must ignore.
    task automatic gap();
        load_valid = 1'b0;
        load_data  = $urandom;
        start      = ($urandom_range(0, 1) == 1);
        tick();
        start     = 1'b0;
        load_data = '0;
        chk_no_write("gap");
        chk_b("gap_ready", load_ready, 1'b1);
    endtask

    // The cycle after the last write: the core must be released and running.
    task automatic enter_run();
        tick();
        chk_b("enter_run_run", run, 1'b1);
        chk_b("enter_run_core_reset_n", core_reset_n, 1'b1);
        chk_b("enter_run_ready", load_ready, 1'b0);
        chk_no_write("enter_run");
    endtask

    // Keep the core running for n cycles, with a stop condition in the nth.
    task automatic run_until(input int n, input bit h, input bit e);
        for (int i = 1; i <= n; i++) begin
            chk_b("running_run", run, 1'b1);
            chk_w("running_cycles", run_cycles, 32'(i - 1));
            chk_b("running_no_inst_strobe", ext_enable_write_inst, 1'b0);
            chk_b("running_no_data_strobe", ext_enable_write_data, 1'b0);
            if (i == n) begin
                halted    = h;
                exception = e;
            end else begin
                start = ($urandom_range(0, 3) == 0);
            end
            tick();
            start     = 1'b0;
            halted    = 1'b0;
            exception = 1'b0;
        end
        chk_b("finish_done", done, 1'b1);
        chk_b("finish_run", run, 1'b0);
        chk_w("finish_run_cycles", run_cycles, 32'(n));
        chk_b("finish_fault", fault, e);
        chk_b("finish_timeout", timeout, 1'b0);
        chk_b("finish_core_reset_n", core_reset_n, 1'b1);
        tick();
        chk_b("done_holds", done, 1'b1);
        chk_b("fault_holds", fault, e);
        chk_w("run_cycles_hold", run_cycles, 32'(n));
    endtask

    task automatic load_random_image(input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 2) == 0) gap();
            send_beat(($urandom_range(0, 1) == 1), $urandom, (i == nbeats - 1));
        end
        enter_run();
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        load_valid   = 1'b0;
        load_data    = '0;
        load_is_data = 1'b0;
        load_last    = 1'b0;
        halted       = 1'b0;
        exception    = 1'b0;
        inst_beats   = 0;
        data_beats   = 0;

        #3;
        chk_reset_state("por");
        tick();
        reset = 1'b0;
        tick();
        chk_reset_state("idle");

        // Directed image: three instruction words and one data word.
        do_start();
        send_beat(1'b0, 32'h11, 1'b0);
        send_beat(1'b0, 32'h22, 1'b0);
        send_beat(1'b0, 32'h33, 1'b0);
        send_beat(1'b1, 32'hAA, 1'b1);
        chk_b("drain_core_reset_n", core_reset_n, 1'b0);
        enter_run();
        run_until(10, 1'b1, 1'b0);

        // Random images with each kind of stop condition.
        do_start();
        load_random_image($urandom_range(4, 20));
        run_until($urandom_range(1, 40), 1'b1, 1'b1);
        do_start();
        load_random_image($urandom_range(4, 20));
        run_until($urandom_range(1, 40), 1'b0, 1'b1);
        do_start();
        load_random_image($urandom_range(4, 20));
        run_until($urandom_range(1, 40), 1'b1, 1'b0);

        // Instruction counter wrap: beat 16385 is written at address 0.
        do_start();
        for (int i = 0; i < 16385; i++) begin
            send_beat(1'b0, $urandom, (i == 16384));
        end
        chk_b("overflow_after_wrap", overflow, 1'b1);
        enter_run();
        run_until(3, 1'b0, 1'b1);
        chk_b("overflow_sticky_in_done", overflow, 1'b1);

        // Asynchronous reset from DONE clears every flag at once.
        #2 reset = 1'b1;
        #1;
        chk_reset_state("reset_in_done");
        tick();
        #2 reset = 1'b0;
        tick();

        // Asynchronous reset while the core is running.
        do_start();
        send_beat(1'b0, 32'h5, 1'b1);
        enter_run();
        tick();
        tick();
        chk_w("pre_reset_run_cycles", run_cycles, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk_reset_state("reset_mid_run");
        tick();
        #2 reset = 1'b0;
        tick();
        chk_reset_state("after_reset_mid_run");

        // Asynchronous reset mid-LOAD with load_valid held. The pending write
        // and the next beat must both be lost.
        do_start();
        send_beat(1'b0, 32'h1, 1'b0);
        send_beat(1'b1, 32'h2, 1'b0);
        load_valid = 1'b1;
        load_data  = 32'hDEAD;
        #2 reset = 1'b1;
        #1;
        chk_reset_state("reset_mid_load");
        tick();
        chk_reset_state("reset_held_load");
        #2 reset = 1'b0;
        tick();
        chk_b("idle_ignores_valid_ready", load_ready, 1'b0);
        chk_no_write("idle_ignores_valid");
        load_valid = 1'b0;
        load_data  = '0;
        do_start();
        send_beat(1'b1, 32'h77, 1'b0);
        send_beat(1'b0, 32'h88, 1'b1);
        enter_run();
        run_until(5, 1'b1, 1'b0);

`ifdef SHADER_RUN_WATCHDOG_EN
        // The core never halts, so the watchdog ends the run at WD cycles.
        do_start();
        send_beat(1'b0, 32'h9, 1'b1);
        enter_run();
        for (int i = 1; i <= WD; i++) begin
            chk_b("wd_running", run, 1'b1);
            chk_w("wd_cycles", run_cycles, 32'(i - 1));
            tick();
        end
        chk_b("wd_done", done, 1'b1);
        chk_b("wd_timeout", timeout, 1'b1);
        chk_b("wd_fault", fault, 1'b0);
        chk_w("wd_run_cycles", run_cycles, 32'(WD));
        chk_b("wd_run_low", run, 1'b0);
`else
        // Without the watchdog, a long run continues until the core halts.
        do_start();
        send_beat(1'b0, 32'h9, 1'b1);
        enter_run();
        run_until(200, 1'b1, 1'b0);
        chk_b("no_wd_timeout", timeout, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
